comparador_limiar: RTL and testbench
====================================

# comparador_limiar

Sequential threshold monitor: compares a stream of unsigned samples against a programmable threshold, resets to 5. Qualifies the "below threshold" condition with a debounce counter and emits registered level and edge-event outputs. A saturating counter tracks qualified entries into the below state. It generalises the fixed 4-bit "less than 5" comparator to any width and runtime threshold, and feeds display/alarm logic in the datapath.

## Interface
- WIDTH, 4, sample and threshold width in bits (≥2)
- THR_RESET, 5, threshold value loaded at reset (< 2^WIDTH)
- DEBOUNCE, 3, consecutive valid samples needed to change state (≥1)
- COUNT_W, 8, width of event counter
- HYST, 1, hysteresis margin; used only with COMPARADOR_LIMIAR_HYST_EN
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset; one clock, synchronous, active-high
- load_thr  input  1  load thr_in into threshold register
- thr_in  input  WIDTH  new threshold
- valid  input  1  value is a sample this cycle
- value  input  WIDTH  unsigned sample
- below  output  1  qualified level: 1 while in BELOW or PEND_ABOVE
- rise_evt  output  1  one-cycle pulse on entering BELOW
- fall_evt  output  1  one-cycle pulse on leaving to ABOVE
- below_cnt  output  COUNT_W  count of BELOW entries, saturating
- thr  output  WIDTH  current threshold

## Operation
- Raw condition: lt = (value < thr), unsigned compare.
- FSM states: ABOVE, PEND_BELOW, BELOW, PEND_ABOVE. Debounce counter deb, width clog2(DEBOUNCE+1).
- ABOVE: valid&lt → PEND_BELOW, deb=1; if DEBOUNCE==1, go directly to BELOW with rise_evt.
- PEND_BELOW: valid&lt → deb+1; deb reaches DEBOUNCE → BELOW, rise_evt=1, below_cnt+1. valid&!lt → ABOVE, deb=0.
- BELOW: valid&!lt → PEND_ABOVE, deb=1 (DEBOUNCE==1: straight to ABOVE, fall_evt).
- PEND_ABOVE: valid&!lt → deb+1; reaching DEBOUNCE → ABOVE, fall_evt=1. valid&lt → BELOW, deb=0.
- valid=0: state and deb hold; no events.
- load_thr: thr ← thr_in at the edge. A sample in the same cycle compares against the old thr. deb clears to 0. PEND_* states fall back to their origin (ABOVE/BELOW). Settled states hold.
- below_cnt saturates at 2^COUNT_W−1; never wraps.
- Reset values: state ABOVE, deb 0, below 0, rise_evt 0, fall_evt 0, below_cnt 0, thr THR_RESET.
- Reset mid-debounce discards progress; no event is emitted.

## Timing
- All outputs registered. Sample at edge N affects below/events at edge N (visible cycle N+1).
- Minimum latency, stable input → below change: DEBOUNCE valid cycles.
- rise_evt and fall_evt are never both high; each lasts exactly one cycle.
- rst dominates load_thr and valid.

## Configuration
- COMPARADOR_LIMIAR_HYST_EN defined: exit condition in BELOW/PEND_ABOVE becomes value ≥ thr+HYST.
  - The sum is computed at WIDTH+1 bits. If thr+HYST > 2^WIDTH−1, exit is impossible and the block stays BELOW until reset or threshold load.
  - Entry condition is unchanged.
- Macro undefined: exit condition is !lt; HYST is ignored.

## Structure
- Package comparador_limiar_pkg: state enum (ABOVE, PEND_BELOW, BELOW, PEND_ABOVE) and a state-encoding width constant.
- Sub-module contador_sat: parametrised saturating counter (inc, rst, count) used for below_cnt.
- FSM, debounce counter and threshold register stay in the top module.

## Test plan
- Reset, then idle → below=0, below_cnt=0, thr=5, no events.
- Defaults, valid=1, values 4,4,4 → rise_evt pulse after the third sample, below=1, below_cnt=1. Then 5,5,5 → fall_evt pulse, below=0.
- Values 4,4,6,4,4 → no rise_evt, because deb restarts on 6. A gap with valid=0 between 4s still completes the debounce.
- load_thr with thr_in=10 and value=7 in the same cycle → compares against 5 (no progress). Following samples of 7 ×3 → rise_evt.
- COUNT_W=2, 5 rise cycles → below_cnt sticks at 3.
- With HYST_EN and HYST=2 in BELOW: value 5 ×3 stays BELOW, value 7 ×3 gives fall_evt. With thr=15 (WIDTH=4): never exits.

Source files
------------

// File: rtl/comparador_limiar_pkg.sv
// Shared types for the comparador_limiar threshold monitor: FSM state encoding.
package comparador_limiar_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ABOVE      = 2'd0,
    ST_PEND_BELOW = 2'd1,
    ST_BELOW      = 2'd2,
    ST_PEND_ABOVE = 2'd3
  } state_e;

endpackage

// File: rtl/comparador_limiar_contador_sat.sv
// Saturating up-counter: increments on inc, sticks at all-ones, synchronous active-high reset.
module contador_sat #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Hold at the ceiling instead of wrapping to zero.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/comparador_limiar.sv
// Debounced "value below threshold" monitor with edge events and a saturating entry counter.
// Optional hysteresis on the exit condition is enabled by defining COMPARADOR_LIMIAR_HYST_EN.
module comparador_limiar
  import comparador_limiar_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned THR_RESET = 5,
  parameter int unsigned DEBOUNCE  = 3,
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned HYST      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_thr,
  input  logic [WIDTH-1:0]   thr_in,
  input  logic               valid,
  input  logic [WIDTH-1:0]   value,
  output logic               below,
  output logic               rise_evt,
  output logic               fall_evt,
  output logic [COUNT_W-1:0] below_cnt,
  output logic [WIDTH-1:0]   thr
);

  localparam int unsigned DEB_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned CMP_W   = WIDTH + 1;
`ifdef COMPARADOR_LIMIAR_HYST_EN
  localparam int unsigned HYST_EFF = HYST;
`else
  // Zero margin makes the exit test collapse to !(value < thr).
  localparam int unsigned HYST_EFF = HYST * 0;
`endif

  state_e           state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic             below_q, below_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  logic             lt_c;
  logic             exit_c;
  logic [DEB_W-1:0] deb_inc_c;
  logic [CMP_W-1:0] exit_thr_c;

  // Exit bound is formed one bit wider so thr+HYST past full scale simply never matches.
  assign lt_c       = value < thr_q;
  assign exit_thr_c = {1'b0, thr_q} + CMP_W'(HYST_EFF);
  assign exit_c     = {1'b0, value} >= exit_thr_c;
  assign deb_inc_c  = deb_q + DEB_W'(1);

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    thr_d   = thr_q;
    if (load_thr) begin
      // New threshold invalidates any debounce in progress; settled states keep their level.
      thr_d = thr_in;
      deb_d = '0;
      if (state_q == ST_PEND_BELOW) begin
        state_d = ST_ABOVE;
      end else if (state_q == ST_PEND_ABOVE) begin
        state_d = ST_BELOW;
      end
    end else if (valid) begin
      case (state_q)
        ST_ABOVE: begin
          if (lt_c) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_BELOW;
              rise_d  = 1'b1;
            end else begin
              state_d = ST_PEND_BELOW;
              deb_d   = DEB_W'(1);
            end
          end
        end
        ST_PEND_BELOW: begin
          if (lt_c) begin
            if (deb_inc_c == DEB_W'(DEBOUNCE)) begin
              state_d = ST_BELOW;
              deb_d   = '0;
              rise_d  = 1'b1;
            end else begin
              deb_d = deb_inc_c;
            end
          end else begin
            state_d = ST_ABOVE;
            deb_d   = '0;
          end
        end
        ST_BELOW: begin
          if (exit_c) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_ABOVE;
              fall_d  = 1'b1;
            end else begin
              state_d = ST_PEND_ABOVE;
              deb_d   = DEB_W'(1);
            end
          end
        end
        ST_PEND_ABOVE: begin
          if (exit_c) begin
            if (deb_inc_c == DEB_W'(DEBOUNCE)) begin
              state_d = ST_ABOVE;
              deb_d   = '0;
              fall_d  = 1'b1;
            end else begin
              deb_d = deb_inc_c;
            end
          end else begin
            state_d = ST_BELOW;
            deb_d   = '0;
          end
        end
        default: begin
          state_d = ST_ABOVE;
          deb_d   = '0;
        end
      endcase
    end
    below_d = (state_d == ST_BELOW) || (state_d == ST_PEND_ABOVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ABOVE;
      deb_q   <= '0;
      thr_q   <= WIDTH'(THR_RESET);
      below_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      thr_q   <= thr_d;
      below_q <= below_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  contador_sat #(
    .W (COUNT_W)
  ) u_below_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rise_d),
    .count (below_cnt)
  );

  assign below    = below_q;
  assign rise_evt = rise_q;
  assign fall_evt = fall_q;
  assign thr      = thr_q;

endmodule

// File: tb/tb_comparador_limiar.sv
// Bench for comparador_limiar: directed scenarios plus randomized traffic against a level/run-length model.
module tb_comparador_limiar;

  localparam int WIDTH    = 4;
  localparam int DEBOUNCE = 3;
  localparam int HYST     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_thr;
  logic [WIDTH-1:0] thr_in;
  logic             valid;
  logic [WIDTH-1:0] value;

  logic             below, rise_evt, fall_evt;
  logic [7:0]       below_cnt;
  logic [WIDTH-1:0] thr;
  logic             s_below, s_rise, s_fall;
  logic [1:0]       s_cnt;
  logic [WIDTH-1:0] s_thr;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: settled level, length of the current qualifying run, entry count, threshold.
  bit m_below;
  int m_run;
  int m_cnt;
  int m_thr;
  bit m_rise, m_fall;

  always #5 clk = ~clk;

  comparador_limiar #(
    .WIDTH(WIDTH), .THR_RESET(5), .DEBOUNCE(DEBOUNCE), .COUNT_W(8), .HYST(HYST)
  ) dut (
    .clk(clk), .rst(rst), .load_thr(load_thr), .thr_in(thr_in), .valid(valid), .value(value),
    .below(below), .rise_evt(rise_evt), .fall_evt(fall_evt), .below_cnt(below_cnt), .thr(thr)
  );

  comparador_limiar #(
    .WIDTH(WIDTH), .THR_RESET(5), .DEBOUNCE(DEBOUNCE), .COUNT_W(2), .HYST(HYST)
  ) dut_sat (
    .clk(clk), .rst(rst), .load_thr(load_thr), .thr_in(thr_in), .valid(valid), .value(value),
    .below(s_below), .rise_evt(s_rise), .fall_evt(s_fall), .below_cnt(s_cnt), .thr(s_thr)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exits(input int v, input int t);
`ifdef COMPARADOR_LIMIAR_HYST_EN
    return v >= t + HYST;
`else
    return !(v < t);
`endif
  endfunction

  task automatic model_edge();
    bit cond;
    m_rise = 0;
    m_fall = 0;
    if (rst) begin
      m_below = 0; m_run = 0; m_cnt = 0; m_thr = 5;
    end else if (load_thr) begin
      m_thr = int'(thr_in);
      m_run = 0;
    end else if (valid) begin
      cond = m_below ? exits(int'(value), m_thr) : (int'(value) < m_thr);
      if (cond) begin
        m_run++;
        if (m_run == DEBOUNCE) begin
          m_run   = 0;
          m_below = !m_below;
          if (m_below) begin
            m_rise = 1;
            m_cnt++;
          end else begin
            m_fall = 1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input int ti, input logic v, input int val);
    rst      = r;
    load_thr = l;
    thr_in   = WIDTH'(ti);
    valid    = v;
    value    = WIDTH'(val);
    @(posedge clk);
    model_edge();
    #1;
    check("below", int'(below), int'(m_below));
    check("rise", int'(rise_evt), int'(m_rise));
    check("fall", int'(fall_evt), int'(m_fall));
    check("cnt", int'(below_cnt), (m_cnt > 255) ? 255 : m_cnt);
    check("thr", int'(thr), m_thr);
    check("evt_excl", int'(rise_evt & fall_evt), 0);
    check("sat_below", int'(s_below), int'(m_below));
    check("sat_cnt", int'(s_cnt), (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic samp(input int val);
    step(1'b0, 1'b0, 0, 1'b1, val);
  endtask

  initial begin
    rst = 1'b1; load_thr = 1'b0; thr_in = '0; valid = 1'b0; value = '0;

    // Reset then idle
    step(1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0);
    check("rst_below", int'(below), 0);
    check("rst_cnt", int'(below_cnt), 0);
    check("rst_thr", int'(thr), 5);
    check("rst_rise", int'(rise_evt), 0);

    // 4,4,4 enters below on the third sample
    samp(4); samp(4);
    check("pre_rise", int'(below), 0);
    samp(4);
    check("rise_444", int'(rise_evt), 1);
    check("below_444", int'(below), 1);
    check("cnt_444", int'(below_cnt), 1);
    samp(5); samp(5); samp(5);
    check("fall_555", int'(fall_evt), 1);
    check("below_555", int'(below), 0);

    // A 6 restarts the run; an idle gap does not
    samp(4); samp(4); samp(6); samp(4); samp(4);
    check("no_rise_restart", int'(below), 0);
    step(1'b0, 1'b0, 0, 1'b0, 4);
    check("gap_hold", int'(below), 0);
    samp(4);
    check("gap_rise", int'(rise_evt), 1);
    samp(5); samp(5); samp(5);

    // Threshold load with a same-cycle sample, then 7 x3 against the new threshold
    step(1'b0, 1'b1, 10, 1'b1, 7);
    check("load_thr", int'(thr), 10);
    check("load_below", int'(below), 0);
    samp(7); samp(7);
    check("load_no_rise", int'(below), 0);
    samp(7);
    check("load_rise", int'(rise_evt), 1);

    // Reset mid-debounce discards progress
    samp(12); samp(12);
    step(1'b1, 1'b0, 0, 1'b1, 12);
    check("rst_mid_fall", int'(fall_evt), 0);
    check("rst_mid_thr", int'(thr), 5);

    // Repeated entries saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      samp(1); samp(1); samp(1);
      samp(15); samp(15); samp(15);
    end
    check("sat_stick", int'(s_cnt), 3);
    check("wide_cnt", int'(below_cnt), 5);

`ifdef COMPARADOR_LIMIAR_HYST_EN
    // Hysteresis: 5 is inside the band, 7 leaves; threshold 15 can never be left
    step(1'b1, 1'b0, 0, 1'b0, 0);
    samp(4); samp(4); samp(4);
    samp(5); samp(5); samp(5);
    check("hyst_hold", int'(below), 1);
    samp(7); samp(7); samp(7);
    check("hyst_fall", int'(fall_evt), 1);
    step(1'b0, 1'b1, 15, 1'b0, 0);
    samp(14); samp(14); samp(14);
    for (int k = 0; k < 6; k++) samp(15);
    check("hyst_stuck", int'(below), 1);
`endif

    // Randomized traffic
    step(1'b1, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, l, v;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, l, $urandom_range(0, 15), v, $urandom_range(0, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
